// File: rtl/branch_target_buffer.sv
// Fully-associative branch target buffer with round-robin replacement.
// IF side: zero-latency tag lookup that yields the taken decision and next fetch PC.
// EX side: one-hot hit and allocate strobes for the per-entry 2-bit predictor slices.
// Optional macro BTB_BYPASS_EN forwards a same-cycle EX allocation/refresh into IF.
module branch_target_buffer #(
    parameter int unsigned ENTRIES = 8,
    parameter int unsigned IDX_W   = 3,
    parameter int unsigned PC_W    = 32
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [PC_W-1:0]     IF_PC,
    input  logic [ENTRIES-1:0]  JumpPredict,
    output logic [ENTRIES-1:0]  IF_Hit,
    output logic                IF_Taken,
    output logic [PC_W-1:0]     IF_NextPC,
    input  logic                EX_Valid,
    input  logic [PC_W-1:0]     EX_PC,
    input  logic                EX_Success,
    input  logic [PC_W-1:0]     EX_Target,
    output logic [ENTRIES-1:0]  EX_Hit,
    output logic [ENTRIES-1:0]  Preset,
    input  logic                Flush
);

    localparam int unsigned TAG_W = PC_W - 2;
    localparam logic [ENTRIES-1:0] OneHot0 = {{(ENTRIES-1){1'b0}}, 1'b1};

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [PC_W-1:0]    target_q [ENTRIES];
    logic [IDX_W-1:0]   rp_q;

    logic               if_found;
    logic [IDX_W-1:0]   if_idx;
    logic               ex_found;
    logic [IDX_W-1:0]   ex_idx;
    logic               alloc;
    logic               refresh;
    logic [PC_W-1:0]    pc_plus4;

    // Word-aligned compares: the byte-offset bits of EX_PC never matter.
    logic unused_ex_pc_lo;
    assign unused_ex_pc_lo = ^EX_PC[1:0];

    // Tag match on both ports; descending scan so the lowest matching index wins.
    always_comb begin
        if_found = 1'b0;
        if_idx   = '0;
        ex_found = 1'b0;
        ex_idx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (valid_q[i] && (tag_q[i] == IF_PC[PC_W-1:2])) begin
                if_found = 1'b1;
                if_idx   = IDX_W'(i);
            end
            if (valid_q[i] && (tag_q[i] == EX_PC[PC_W-1:2])) begin
                ex_found = 1'b1;
                ex_idx   = IDX_W'(i);
            end
        end
    end

    // EX-side strobes; allocation is gated by reset so Preset stays quiet while held.
    always_comb begin
        alloc   = RST_N & EX_Valid & ~ex_found & EX_Success;
        refresh = EX_Valid & ex_found & EX_Success;
        EX_Hit  = (EX_Valid && ex_found) ? (OneHot0 << ex_idx) : '0;
        Preset  = alloc ? (OneHot0 << rp_q) : '0;
    end

    // IF-side prediction from registered contents, optionally overridden by EX forwarding.
    always_comb begin
        pc_plus4  = IF_PC + PC_W'(4);
        IF_Hit    = if_found ? (OneHot0 << if_idx) : '0;
        IF_Taken  = |(IF_Hit & JumpPredict);
        IF_NextPC = IF_Taken ? target_q[if_idx] : pc_plus4;
`ifdef BTB_BYPASS_EN
        if (RST_N && EX_Valid && EX_Success && (EX_PC[PC_W-1:2] == IF_PC[PC_W-1:2])) begin
            IF_Hit    = ex_found ? (OneHot0 << ex_idx) : (OneHot0 << rp_q);
            IF_Taken  = 1'b1;
            IF_NextPC = EX_Target;
        end
`endif
    end

    // Storage update: flush beats allocation, allocation and refresh are exclusive.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            valid_q <= '0;
            rp_q    <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
            end
        end else if (Flush) begin
            valid_q <= '0;
            rp_q    <= '0;
        end else if (alloc) begin
            valid_q[rp_q]  <= 1'b1;
            tag_q[rp_q]    <= EX_PC[PC_W-1:2];
            target_q[rp_q] <= EX_Target;
            rp_q           <= rp_q + IDX_W'(1);
        end else if (refresh) begin
            target_q[ex_idx] <= EX_Target;
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed table-driven bench for branch_target_buffer plus hand-written multi-cycle sequences.
module tb_branch_target_buffer;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [31:0] IF_PC;
    logic [7:0]  JumpPredict;
    logic [7:0]  IF_Hit;
    logic        IF_Taken;
    logic [31:0] IF_NextPC;
    logic        EX_Valid;
    logic [31:0] EX_PC;
    logic        EX_Success;
    logic [31:0] EX_Target;
    logic [7:0]  EX_Hit;
    logic [7:0]  Preset;
    logic        Flush;

    int n_vec = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    branch_target_buffer #(.ENTRIES(8), .IDX_W(3), .PC_W(32)) dut (
        .CLK(CLK), .RST_N(RST_N), .IF_PC(IF_PC), .JumpPredict(JumpPredict),
        .IF_Hit(IF_Hit), .IF_Taken(IF_Taken), .IF_NextPC(IF_NextPC),
        .EX_Valid(EX_Valid), .EX_PC(EX_PC), .EX_Success(EX_Success), .EX_Target(EX_Target),
        .EX_Hit(EX_Hit), .Preset(Preset), .Flush(Flush)
    );

    typedef struct {
        logic        ex_valid;
        logic [31:0] ex_pc;
        logic        ex_success;
        logic [31:0] ex_target;
        logic [31:0] if_pc;
        logic [7:0]  jp;
        logic        flush;
        logic [7:0]  e_if_hit;
        logic        e_taken;
        logic [31:0] e_next;
        logic [7:0]  e_ex_hit;
        logic [7:0]  e_preset;
    } vec_t;

    vec_t tbl [13];

    function automatic vec_t mk(input logic ev, input logic [31:0] ep, input logic es,
                                input logic [31:0] et, input logic [31:0] ip,
                                input logic [7:0] jp, input logic fl, input logic [7:0] ih,
                                input logic tk, input logic [31:0] nx, input logic [7:0] eh,
                                input logic [7:0] ps);
        vec_t v;
        v.ex_valid = ev; v.ex_pc = ep; v.ex_success = es; v.ex_target = et;
        v.if_pc = ip; v.jp = jp; v.flush = fl;
        v.e_if_hit = ih; v.e_taken = tk; v.e_next = nx; v.e_ex_hit = eh; v.e_preset = ps;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ev, input logic [31:0] ep, input logic es,
                         input logic [31:0] et, input logic [31:0] ip, input logic [7:0] jp,
                         input logic fl);
        EX_Valid = ev; EX_PC = ep; EX_Success = es; EX_Target = et;
        IF_PC = ip; JumpPredict = jp; Flush = fl;
    endtask

    task automatic chk_all(input string tag, input logic [7:0] ih, input logic tk,
                           input logic [31:0] nx, input logic [7:0] eh, input logic [7:0] ps);
        chk({tag, " IF_Hit"}, 32'(IF_Hit), 32'(ih));
        chk({tag, " IF_Taken"}, 32'(IF_Taken), 32'(tk));
        chk({tag, " IF_NextPC"}, IF_NextPC, nx);
        chk({tag, " EX_Hit"}, 32'(EX_Hit), 32'(eh));
        chk({tag, " Preset"}, 32'(Preset), 32'(ps));
    endtask

    initial begin
        // Table: each record is one cycle; outputs checked before the committing edge.
`ifdef BTB_BYPASS_EN
        tbl[0]  = mk(1, 32'h0040_0010, 1, 32'h0040_0100, 32'h0040_0010, 8'hFF, 0,
                     8'h01, 1, 32'h0040_0100, 8'h00, 8'h01);
        tbl[10] = mk(1, 32'h0040_0060, 1, 32'h0040_0200, 32'h0040_0060, 8'h08, 0,
                     8'h08, 1, 32'h0040_0200, 8'h08, 8'h00);
`else
        tbl[0]  = mk(1, 32'h0040_0010, 1, 32'h0040_0100, 32'h0040_0010, 8'hFF, 0,
                     8'h00, 0, 32'h0040_0014, 8'h00, 8'h01);
        tbl[10] = mk(1, 32'h0040_0060, 1, 32'h0040_0200, 32'h0040_0060, 8'h08, 0,
                     8'h08, 1, 32'h0040_0660, 8'h08, 8'h00);
`endif
        tbl[1]  = mk(0, 32'h0, 0, 32'h0, 32'h0040_0010, 8'h01, 0,
                     8'h01, 1, 32'h0040_0100, 8'h00, 8'h00);
        tbl[2]  = mk(0, 32'h0, 0, 32'h0, 32'h0040_0010, 8'h00, 0,
                     8'h01, 0, 32'h0040_0014, 8'h00, 8'h00);
        tbl[3]  = mk(1, 32'h0040_0020, 0, 32'h0040_0300, 32'h0040_0020, 8'hFF, 0,
                     8'h00, 0, 32'h0040_0024, 8'h00, 8'h00);
        tbl[4]  = mk(1, 32'h0040_0030, 1, 32'h0040_0330, 32'h0040_0020, 8'hFF, 0,
                     8'h00, 0, 32'h0040_0024, 8'h00, 8'h02);
        tbl[5]  = mk(1, 32'h0040_0010, 0, 32'h0040_0999, 32'h0040_0030, 8'h02, 0,
                     8'h02, 1, 32'h0040_0330, 8'h01, 8'h00);
        tbl[6]  = mk(0, 32'h0040_0030, 1, 32'h0040_0777, 32'h0040_0010, 8'h01, 0,
                     8'h01, 1, 32'h0040_0100, 8'h00, 8'h00);
        tbl[7]  = mk(0, 32'h0040_0040, 1, 32'h0040_0440, 32'h0040_0040, 8'hFF, 0,
                     8'h00, 0, 32'h0040_0044, 8'h00, 8'h00);
        tbl[8]  = mk(1, 32'h0040_0050, 1, 32'h0040_0550, 32'h0040_0040, 8'hFF, 0,
                     8'h00, 0, 32'h0040_0044, 8'h00, 8'h04);
        tbl[9]  = mk(1, 32'h0040_0060, 1, 32'h0040_0660, 32'hFFFF_FFFC, 8'hFF, 0,
                     8'h00, 0, 32'h0000_0000, 8'h00, 8'h08);
        tbl[11] = mk(0, 32'h0, 0, 32'h0, 32'h0040_0060, 8'h08, 0,
                     8'h08, 1, 32'h0040_0200, 8'h00, 8'h00);
        tbl[12] = mk(0, 32'h0, 0, 32'h0, 32'h0040_0063, 8'h08, 0,
                     8'h08, 1, 32'h0040_0200, 8'h00, 8'h00);

        // Power-on reset.
        RST_N = 1'b0;
        drive(0, 32'h0, 0, 32'h0, 32'h0040_0010, 8'hFF, 0);
        #1;
        chk_all("reset", 8'h00, 0, 32'h0040_0014, 8'h00, 8'h00);
        @(negedge CLK);
        RST_N = 1'b1;

        for (int i = 0; i < 13; i++) begin
            @(negedge CLK);
            drive(tbl[i].ex_valid, tbl[i].ex_pc, tbl[i].ex_success, tbl[i].ex_target,
                  tbl[i].if_pc, tbl[i].jp, tbl[i].flush);
            #1;
            chk_all($sformatf("v%0d", i), tbl[i].e_if_hit, tbl[i].e_taken, tbl[i].e_next,
                    tbl[i].e_ex_hit, tbl[i].e_preset);
        end

        // Mid-cycle async reset with an allocation pending; the write must be dropped.
        @(negedge CLK);
        drive(1, 32'h0040_0070, 1, 32'h0040_0770, 32'h0040_0060, 8'hFF, 0);
        #1;
        chk("pre-reset IF_Hit", 32'(IF_Hit), 32'h08);
        #1;
        RST_N = 1'b0;
        #1;
        chk_all("mid reset", 8'h00, 0, 32'h0040_0064, 8'h00, 8'h00);
        @(negedge CLK);
        RST_N = 1'b1;
        drive(0, 32'h0, 0, 32'h0, 32'h0040_0070, 8'hFF, 0);
        #1;
        chk("dropped write IF_Hit", 32'(IF_Hit), 32'h00);
        @(negedge CLK);
        drive(1, 32'h0040_0070, 1, 32'h0040_0770, 32'h0040_0060, 8'hFF, 0);
        #1;
        chk("post reset Preset", 32'(Preset), 32'h01);

        // Wrap-around: nine distinct taken branches after a flush.
        @(negedge CLK);
        drive(0, 32'h0, 0, 32'h0, 32'h0000_0100, 8'h00, 1);
        for (int k = 0; k < 9; k++) begin
            @(negedge CLK);
            drive(1, 32'h0040_1000 + 32'(k * 16), 1, 32'h0050_0000 + 32'(k * 256),
                  32'h0000_0100, 8'hFF, 0);
            #1;
            chk($sformatf("wrap alloc%0d Preset", k), 32'(Preset), 32'(8'h01 << (k % 8)));
            chk($sformatf("wrap alloc%0d EX_Hit", k), 32'(EX_Hit), 32'h0);
        end
        for (int k = 0; k < 9; k++) begin
            @(negedge CLK);
            drive(0, 32'h0, 0, 32'h0, 32'h0040_1000 + 32'(k * 16), 8'hFF, 0);
            #1;
            if (k == 0) begin
                chk("wrap pc0 IF_Hit", 32'(IF_Hit), 32'h0);
                chk("wrap pc0 IF_NextPC", IF_NextPC, 32'h0040_1004);
            end else begin
                chk($sformatf("wrap pc%0d IF_Hit", k), 32'(IF_Hit), 32'(8'h01 << (k % 8)));
                chk($sformatf("wrap pc%0d IF_NextPC", k), IF_NextPC,
                    32'h0050_0000 + 32'(k * 256));
            end
        end

        // Flush in the same cycle as an allocation: strobe still driven, state cleared.
        @(negedge CLK);
        drive(1, 32'h0040_2000, 1, 32'h0050_2000, 32'h0000_0100, 8'hFF, 1);
        #1;
        chk("flush cycle Preset", 32'(Preset), 32'h02);
        for (int k = 1; k < 9; k++) begin
            @(negedge CLK);
            drive(0, 32'h0, 0, 32'h0, 32'h0040_1000 + 32'(k * 16), 8'hFF, 0);
            #1;
            chk($sformatf("flushed pc%0d IF_Hit", k), 32'(IF_Hit), 32'h0);
        end
        @(negedge CLK);
        drive(0, 32'h0, 0, 32'h0, 32'h0040_2000, 8'hFF, 0);
        #1;
        chk("flushed alloc IF_Hit", 32'(IF_Hit), 32'h0);
        @(negedge CLK);
        drive(1, 32'h0040_3000, 1, 32'h0050_3000, 32'h0000_0100, 8'hFF, 0);
        #1;
        chk("post flush Preset", 32'(Preset), 32'h01);
        @(negedge CLK);
        drive(0, 32'h0, 0, 32'h0, 32'h0040_3000, 8'hFF, 0);
        #1;
        chk("post flush IF_NextPC", IF_NextPC, 32'h0050_3000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
- Fully-associative branch target buffer (BTB) for the IF/EX stages of the pipelined MIPS CPU.
- Directly upstream of the per-entry 2-bit predictor slices:
  - drives each slice's Hit, EX_Hit and Preset lines (one-hot per entry);
  - consumes each slice's JumpPredict.
- Produces the IF-stage taken decision and next-PC target.
- Learns branch targets from EX-stage resolution using round-robin replacement.

Parameters:
- ENTRIES, 8, number of BTB entries; must be a power of two, at least 2.
- IDX_W, 3, log2(ENTRIES).
- PC_W, 32, PC / tag / target width; byte address, bits [1:0] ignored in compares.

Ports:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous active-low reset.
- IF_PC  in  PC_W  fetch PC.
- JumpPredict  in  ENTRIES  per-entry predictor outputs.
- IF_Hit  out  ENTRIES  one-hot match of IF_PC; feeds each predictor's Hit.
- IF_Taken  out  1  predicted taken.
- IF_NextPC  out  PC_W  next fetch address.
- EX_Valid  in  1  branch resolved in EX this cycle.
- EX_PC  in  PC_W  PC of the resolved branch.
- EX_Success  in  1  branch actually taken; also drives each predictor's Success.
- EX_Target  in  PC_W  resolved target.
- EX_Hit  out  ENTRIES  one-hot EX match; feeds each predictor's EX_Hit.
- Preset  out  ENTRIES  one-hot allocation strobe; feeds each predictor's Preset.
- Flush  in  1  synchronous invalidate-all.

Behaviour:
- Storage per entry: valid, tag[PC_W-1:2], target[PC_W-1:0]. Replacement pointer rp[IDX_W-1:0].
- Reset (RST_N low, async): all valid=0, rp=0. Tag and target contents don't-care.
- Reset effect on outputs: IF_Hit=0, EX_Hit=0, Preset=0, IF_Taken=0, IF_NextPC=IF_PC+4.
- Reset asserted mid-update: the pending write is discarded.
- Lookup (combinational, zero latency):
  - IF_Hit[i] = valid[i] & (tag[i]==IF_PC[PC_W-1:2]).
  - Multiple matches cannot occur by construction. If they do, the lowest index wins and IF_Hit is masked to that index.
  - IF_Taken = |(IF_Hit & JumpPredict).
  - IF_NextPC = IF_Taken ? target[hit] : IF_PC+4 (mod 2^PC_W; wraps at top of address space).
- EX match (combinational): m[i] = valid[i] & (tag[i]==EX_PC[PC_W-1:2]).
  - EX_Hit = EX_Valid ? m (lowest-index masked) : 0.
- Allocation condition: EX_Valid & ~|m & EX_Success.
  - Preset = one-hot(rp) when the condition holds, else 0.
  - Predictor slices capture Preset at the same CLK edge and initialise to strongly-taken (2'b11).
- Update at posedge CLK when EX_Valid:
  - Hit and EX_Success: target[hit] <= EX_Target (target refresh). Valid and rp unchanged.
  - Hit and not EX_Success: no storage change (predictor handles the count-down).
  - Miss and EX_Success: valid[rp]<=1, tag[rp]<=EX_PC[PC_W-1:2], target[rp]<=EX_Target, rp<=rp+1 mod ENTRIES. The oldest entry is overwritten even if other entries are invalid.
  - Miss and not EX_Success: no allocation.
- Flush (sampled at posedge):
  - all valid<=0, rp<=0.
  - Flush has priority over a same-cycle update; EX_Hit and Preset are still driven combinationally that cycle.
- Same-cycle IF lookup of the PC being written by EX: IF sees pre-edge contents (miss / old target) unless the optional feature is enabled.
- EX_Valid low: EX_Hit=0, Preset=0, no state change.

Optional Feature:
- Macro: BTB_BYPASS_EN.
- When defined: if EX_Valid & EX_Success & (EX_PC[PC_W-1:2]==IF_PC[PC_W-1:2]) in the same cycle:
  - IF_NextPC = EX_Target;
  - IF_Taken = 1;
  - IF_Hit = one-hot of the entry being hit or allocated.
- When undefined: no forwarding; lookup reflects registered state only.

Test Plan:
- Reset: RST_N=0 asynchronously, mid-cycle -> IF_Hit=0, IF_Taken=0, IF_NextPC=IF_PC+4 immediately. First allocation after release lands in entry 0.
- Allocate then hit:
  - Cycle 1: EX_Valid=1, EX_PC=0x0040_0010, EX_Success=1, EX_Target=0x0040_0100 -> Preset=8'b0000_0001, EX_Hit=0.
  - Next cycle: IF_PC=0x0040_0010 with JumpPredict[0]=1 -> IF_Hit[0]=1, IF_NextPC=0x0040_0100.
  - Same lookup with JumpPredict[0]=0 -> IF_NextPC=0x0040_0014.
- Not-taken miss: EX_Valid=1, EX_Success=0, new PC -> Preset=0, no entry valid, rp unchanged.
- Wrap-around: 9 distinct taken branches -> 9th allocation pulses Preset[0] and rp wraps to 1. The first PC now misses; PCs 2..9 hit.
- Target refresh and flush:
  - Hit on entry 3 with EX_Success=1, new EX_Target=0x0040_0200 -> EX_Hit[3]=1, Preset=0, next lookup returns 0x0040_0200.
  - Flush=1 same cycle as an allocation -> all entries miss afterwards, rp=0.
- Bypass: with BTB_BYPASS_EN, IF_PC==EX_PC on the allocating cycle -> IF_NextPC=EX_Target that cycle. Without the macro -> IF_PC+4.
